id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the CP0/MFC0 bubble logic and the load-use bubble logic. When either asserts, it captures a NOP into EX and holds PC and IF/ID. Its registered `ex_Rw` and `ex_cp0Op` outputs feed back into that same bubble logic, so the block both consumes and feeds the hazard detection.

## Interface
Parameters:
- `NOP_ALUOP`, default 4'b0000: ALU op loaded with a bubble.
- `CNT_W`, default 16: width of the bubble statistics counter.

Ports:
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: reset, synchronous, active-low.
- `cp0Bubble` input, 1: MFC0-use hazard; insert a bubble.
- `loadBubble` input, 1: load-use hazard; insert a bubble.
- `flush` input, 1: exception or ERET redirect; kill the ID instruction.
- `hold` input, 1: downstream stall; freeze ID/EX.
- `id_valid` input, 1: ID slot holds a real instruction.
- `id_pc` input, 32: PC of the ID instruction.
- `id_busA`, `id_busB`, `id_imm32` inputs, 32 each: operands.
- `id_Ra`, `id_Rb`, `id_Rw` inputs, 5 each: register specifiers.
- `id_regWr`, `id_memWr`, `id_memToReg` inputs, 1 each: control bits.
- `id_aluOp` input, 4: ALU operation.
- `id_cp0Op` input, 3: CP0 operation; 3'b001 = MFC0.
- `ex_*` outputs, same widths as the `id_*` inputs: registered copies of every `id_*` field, plus `ex_valid`.
- `pc_stall` output, 1: hold PC this cycle.
- `ifid_stall` output, 1: hold IF/ID this cycle.
- `bubble_cnt` output, `CNT_W`: count of bubbles inserted, saturating.

## Operation
- `bubble_req = cp0Bubble | loadBubble`.
- Per-edge action, highest priority first:
  - **RESET**, `!rst_n`: all `ex_*` = 0, `ex_valid` = 0, `ex_aluOp` = `NOP_ALUOP`, `bubble_cnt` = 0.
  - **FLUSH**, `flush`: load NOP. This applies even when `hold` is high, because the redirect wins.
  - **HOLD**, `hold`: all ex registers keep their values. `bubble_cnt` does not change.
  - **BUBBLE**, `bubble_req`: load NOP and increment `bubble_cnt`.
  - **LOAD**, otherwise: `ex_* <= id_*`, `ex_valid <= id_valid`.
- NOP contents: `ex_valid`, `ex_regWr`, `ex_memWr`, `ex_memToReg` = 0; `ex_Rw` = 0; `ex_cp0Op` = 3'b000; `ex_aluOp` = `NOP_ALUOP`. The data fields (`pc`, `bus`, `imm`, `Ra`, `Rb`) are don't-care and are driven to 0. Forcing `ex_Rw` = 0 and `ex_cp0Op` = 0 guarantees a bubble never re-triggers the hazard by itself.
- `pc_stall = ifid_stall = rst_n & !flush & (hold | bubble_req)`. This path is combinational, so the stall applies in the same cycle the request appears.
- `bubble_cnt`: increments only in the BUBBLE action and saturates at all-ones, with no wrap. A `cp0Bubble` and `loadBubble` asserted in the same cycle count as one bubble.

## Timing
- Latency: ID to EX is 1 cycle.
- A bubble request seen in cycle N produces NOP in EX at N+1. The same instruction stays in ID across that edge and loads at the first edge with `bubble_req` = 0.
- An MFC0 followed by a dependent instruction inserts 2 bubbles, because the hazard holds while the MFC0 is in EX and again while it is in MEM. The dependent instruction enters EX 3 cycles after the MFC0 did.
- Reset mid-stall: the reset edge clears everything. `pc_stall` is 0 while `rst_n` = 0.
- `flush` asserted together with `bubble_req`: NOP is loaded, `bubble_cnt` is not incremented, and no stall is signalled.
- `hold` asserted together with `bubble_req`: registers freeze, no count, stall outputs are 1. The hazard is re-evaluated after `hold` drops.
- All outputs except `pc_stall` and `ifid_stall` are registered.

## Structure
- Shared `pipe_pkg` holds:
  - `CP0OP_MFC0` = 3'b001 and the other cp0Op encodings;
  - the `NOP_ALUOP` value;
  - a packed struct `idex_ctrl_t` {regWr, memWr, memToReg, aluOp, cp0Op, Rw}.
- One sub-module, `pipe_sat_counter`, implements the saturating `CNT_W` counter with an `inc` input. It is reusable for the other stall statistics.
- The field registers are a single flat always block with the priority chain above.

## Test plan
1. Reset: hold `rst_n` = 0 for 2 cycles with random `id_*` applied -> all `ex_*` = 0, `bubble_cnt` = 0, `pc_stall` = 0.
2. Plain flow, no hazards: `id_pc` = 0x400 then 0x404 -> `ex_pc` = 0x400 and then 0x404, one cycle late, with `ex_valid` = 1.
3. MFC0 hazard: MFC0 with `Rw` = 5 (`cp0Op` = 001), then `addu` with `Ra` = 5; the bubble logic asserts `cp0Bubble` for 2 cycles -> 2 NOPs in EX, `pc_stall` high for 2 cycles, `bubble_cnt` = 2, and the `addu` reaches EX on the 3rd edge after the MFC0.
4. Simultaneous `cp0Bubble` and `loadBubble` for 1 cycle -> a single NOP and `bubble_cnt` += 1.
5. `flush` together with `hold` and `cp0Bubble`, with `id_pc` = 0x500 -> `ex_valid` = 0, `ex_Rw` = 0, `pc_stall` = 0, `bubble_cnt` unchanged.
6. Saturation: preload the counter to 0xFFFE, then assert `cp0Bubble` for 3 cycles -> `bubble_cnt` = 0xFFFF and it stays there.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: CP0 op encodings, default bubble ALU op and
// the ID/EX control bundle.
package pipe_pkg;

  localparam logic [2:0] CP0OP_NONE = 3'b000;
  localparam logic [2:0] CP0OP_MFC0 = 3'b001;
  localparam logic [2:0] CP0OP_MTC0 = 3'b010;
  localparam logic [2:0] CP0OP_ERET = 3'b011;

  localparam logic [3:0] NOP_ALUOP_DFLT = 4'b0000;

  typedef struct packed {
    logic       regWr;
    logic       memWr;
    logic       memToReg;
    logic [3:0] aluOp;
    logic [2:0] cp0Op;
    logic [4:0] Rw;
  } idex_ctrl_t;

  // Control bundle of a bubble: nothing written, no CP0 access, no dest reg.
  function automatic idex_ctrl_t make_nop_ctrl(input logic [3:0] nop_alu_op);
    idex_ctrl_t c;
    c.regWr    = 1'b0;
    c.memWr    = 1'b0;
    c.memToReg = 1'b0;
    c.aluOp    = nop_alu_op;
    c.cp0Op    = CP0OP_NONE;
    c.Rw       = 5'd0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion, flush, hold and a
// saturating bubble counter; drives the PC and IF/ID stall lines.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter logic [3:0] NOP_ALUOP = NOP_ALUOP_DFLT,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cp0Bubble,
  input  logic             loadBubble,
  input  logic             flush,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_busA,
  input  logic [31:0]      id_busB,
  input  logic [31:0]      id_imm32,
  input  logic [4:0]       id_Ra,
  input  logic [4:0]       id_Rb,
  input  logic [4:0]       id_Rw,
  input  logic             id_regWr,
  input  logic             id_memWr,
  input  logic             id_memToReg,
  input  logic [3:0]       id_aluOp,
  input  logic [2:0]       id_cp0Op,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_busA,
  output logic [31:0]      ex_busB,
  output logic [31:0]      ex_imm32,
  output logic [4:0]       ex_Ra,
  output logic [4:0]       ex_Rb,
  output logic [4:0]       ex_Rw,
  output logic             ex_regWr,
  output logic             ex_memWr,
  output logic             ex_memToReg,
  output logic [3:0]       ex_aluOp,
  output logic [2:0]       ex_cp0Op,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic       bubble_req;
  logic       cnt_inc;
  idex_ctrl_t id_ctrl;
  idex_ctrl_t nop_ctrl;
  idex_ctrl_t ctrl_q;

  assign bubble_req = cp0Bubble | loadBubble;

  // Stall is combinational so PC and IF/ID hold in the same cycle the
  // hazard appears; a redirect never stalls.
  assign pc_stall   = rst_n & ~flush & (hold | bubble_req);
  assign ifid_stall = pc_stall;

  assign cnt_inc = ~flush & ~hold & bubble_req;

  always_comb begin
    id_ctrl          = '0;
    id_ctrl.regWr    = id_regWr;
    id_ctrl.memWr    = id_memWr;
    id_ctrl.memToReg = id_memToReg;
    id_ctrl.aluOp    = id_aluOp;
    id_ctrl.cp0Op    = id_cp0Op;
    id_ctrl.Rw       = id_Rw;
    nop_ctrl         = make_nop_ctrl(NOP_ALUOP);
  end

  // Priority: reset, flush, hold, bubble, load.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_busA  <= '0;
      ex_busB  <= '0;
      ex_imm32 <= '0;
      ex_Ra    <= '0;
      ex_Rb    <= '0;
      ctrl_q   <= nop_ctrl;
    end else if (!hold) begin
      if (bubble_req) begin
        ex_valid <= 1'b0;
        ex_pc    <= '0;
        ex_busA  <= '0;
        ex_busB  <= '0;
        ex_imm32 <= '0;
        ex_Ra    <= '0;
        ex_Rb    <= '0;
        ctrl_q   <= nop_ctrl;
      end else begin
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_busA  <= id_busA;
        ex_busB  <= id_busB;
        ex_imm32 <= id_imm32;
        ex_Ra    <= id_Ra;
        ex_Rb    <= id_Rb;
        ctrl_q   <= id_ctrl;
      end
    end
  end

  assign ex_regWr    = ctrl_q.regWr;
  assign ex_memWr    = ctrl_q.memWr;
  assign ex_memToReg = ctrl_q.memToReg;
  assign ex_aluOp    = ctrl_q.aluOp;
  assign ex_cp0Op    = ctrl_q.cp0Op;
  assign ex_Rw       = ctrl_q.Rw;

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus random cycles checked
// against a rule-level model of the ID/EX register.
module tb_id_ex_stage_reg;

  localparam logic [3:0] TB_NOP = 4'hA;
  localparam int         CNT_W  = 16;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] imm32;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [4:0]  Rw;
    logic        regWr;
    logic        memWr;
    logic        memToReg;
    logic [3:0]  aluOp;
    logic [2:0]  cp0Op;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n, cp0Bubble, loadBubble, flush, hold;
  logic id_valid, id_regWr, id_memWr, id_memToReg;
  logic [31:0] id_pc, id_busA, id_busB, id_imm32;
  logic [4:0] id_Ra, id_Rb, id_Rw;
  logic [3:0] id_aluOp;
  logic [2:0] id_cp0Op;
  logic ex_valid, ex_regWr, ex_memWr, ex_memToReg, pc_stall, ifid_stall;
  logic [31:0] ex_pc, ex_busA, ex_busB, ex_imm32;
  logic [4:0] ex_Ra, ex_Rb, ex_Rw;
  logic [3:0] ex_aluOp;
  logic [2:0] ex_cp0Op;
  logic [CNT_W-1:0] bubble_cnt;

  int total = 0;
  int bad = 0;
  ex_t m_ex;
  int m_cnt;
  ex_t dut_ex;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .NOP_ALUOP (TB_NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cp0Bubble (cp0Bubble), .loadBubble (loadBubble), .flush (flush), .hold (hold),
    .id_valid (id_valid), .id_pc (id_pc), .id_busA (id_busA), .id_busB (id_busB),
    .id_imm32 (id_imm32), .id_Ra (id_Ra), .id_Rb (id_Rb), .id_Rw (id_Rw),
    .id_regWr (id_regWr), .id_memWr (id_memWr), .id_memToReg (id_memToReg),
    .id_aluOp (id_aluOp), .id_cp0Op (id_cp0Op),
    .ex_valid (ex_valid), .ex_pc (ex_pc), .ex_busA (ex_busA), .ex_busB (ex_busB),
    .ex_imm32 (ex_imm32), .ex_Ra (ex_Ra), .ex_Rb (ex_Rb), .ex_Rw (ex_Rw),
    .ex_regWr (ex_regWr), .ex_memWr (ex_memWr), .ex_memToReg (ex_memToReg),
    .ex_aluOp (ex_aluOp), .ex_cp0Op (ex_cp0Op),
    .pc_stall (pc_stall), .ifid_stall (ifid_stall), .bubble_cnt (bubble_cnt)
  );

  assign dut_ex = '{valid: ex_valid, pc: ex_pc, busA: ex_busA, busB: ex_busB,
                    imm32: ex_imm32, Ra: ex_Ra, Rb: ex_Rb, Rw: ex_Rw,
                    regWr: ex_regWr, memWr: ex_memWr, memToReg: ex_memToReg,
                    aluOp: ex_aluOp, cp0Op: ex_cp0Op};

  function automatic ex_t nop_ex();
    ex_t e = '0;
    e.aluOp = TB_NOP;
    return e;
  endfunction

  function automatic ex_t id_ex();
    ex_t e;
    e = '{valid: id_valid, pc: id_pc, busA: id_busA, busB: id_busB,
          imm32: id_imm32, Ra: id_Ra, Rb: id_Rb, Rw: id_Rw,
          regWr: id_regWr, memWr: id_memWr, memToReg: id_memToReg,
          aluOp: id_aluOp, cp0Op: id_cp0Op};
    return e;
  endfunction

  function automatic logic exp_stall();
    return rst_n && !flush && (hold || cp0Bubble || loadBubble);
  endfunction

  // Advance one edge; the model applies the action rules in priority order.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_ex = nop_ex();
      m_cnt = 0;
    end else if (flush) begin
      m_ex = nop_ex();
    end else if (hold) begin
      m_ex = m_ex;
    end else if (cp0Bubble || loadBubble) begin
      m_ex = nop_ex();
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m_ex = id_ex();
    end
    #1;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom_range(0, 1));
    id_pc = $urandom & 32'hFFFF_FFFC;
    id_busA = $urandom;
    id_busB = $urandom;
    id_imm32 = $urandom;
    id_Ra = 5'($urandom_range(0, 31));
    id_Rb = 5'($urandom_range(0, 31));
    id_Rw = 5'($urandom_range(1, 31));
    id_regWr = 1'($urandom_range(0, 1));
    id_memWr = 1'($urandom_range(0, 1));
    id_memToReg = 1'($urandom_range(0, 1));
    id_aluOp = 4'($urandom_range(0, 15));
    id_cp0Op = 3'($urandom_range(0, 7));
  endtask

  task automatic ctl(input logic c, input logic l, input logic f, input logic h);
    cp0Bubble = c; loadBubble = l; flush = f; hold = h;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rand_id();
      #1;
      total++;
      if (pc_stall !== 1'b0 || ifid_stall !== 1'b0) begin
        bad++;
        $display("FAIL reset_stall got %b/%b exp 0/0", pc_stall, ifid_stall);
      end
      step();
    end
    total++;
    if (dut_ex !== nop_ex()) begin
      bad++;
      $display("FAIL reset_ex got %h exp %h", dut_ex, nop_ex());
    end
    total++;
    if (bubble_cnt !== '0) begin
      bad++;
      $display("FAIL reset_cnt got %h exp 0", bubble_cnt);
    end
    rst_n = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_plain_flow();
    exp_q.delete();
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rand_id();
      id_valid = 1'b1;
      id_pc = 32'h400 + 32'(4 * i);
      exp_q.push_back(id_pc);
      step();
      total++;
      if (ex_pc !== exp_q[0] || ex_valid !== 1'b1) begin
        bad++;
        $display("FAIL plain_pc got %h/%b exp %h/1", ex_pc, ex_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
      total++;
      if (dut_ex !== m_ex) begin
        bad++;
        $display("FAIL plain_ex got %h exp %h", dut_ex, m_ex);
      end
    end
  endtask

  task automatic test_mfc0();
    int cnt0;
    cnt0 = int'(bubble_cnt);
    rand_id();
    id_valid = 1'b1; id_cp0Op = 3'b001; id_Rw = 5'd5; id_pc = 32'h600;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rand_id();
    id_valid = 1'b1; id_cp0Op = 3'b000; id_Ra = 5'd5; id_pc = 32'h604;
    cp0Bubble = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (pc_stall !== 1'b1 || ifid_stall !== 1'b1) begin
        bad++;
        $display("FAIL mfc0_stall cyc %0d got %b/%b exp 1/1", i, pc_stall, ifid_stall);
      end
      step();
      total++;
      if (ex_valid !== 1'b0 || ex_Rw !== 5'd0 || ex_cp0Op !== 3'd0 || ex_aluOp !== TB_NOP) begin
        bad++;
        $display("FAIL mfc0_nop cyc %0d got v=%b rw=%0d cp0=%0d alu=%h", i, ex_valid, ex_Rw, ex_cp0Op, ex_aluOp);
      end
    end
    cp0Bubble = 1'b0;
    #1;
    total++;
    if (pc_stall !== 1'b0) begin
      bad++;
      $display("FAIL mfc0_release got %b exp 0", pc_stall);
    end
    step();
    total++;
    if (ex_pc !== 32'h604 || ex_Ra !== 5'd5 || ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL mfc0_addu got pc=%h ra=%0d v=%b exp 604/5/1", ex_pc, ex_Ra, ex_valid);
    end
    total++;
    if (int'(bubble_cnt) !== cnt0 + 2) begin
      bad++;
      $display("FAIL mfc0_cnt got %0d exp %0d", bubble_cnt, cnt0 + 2);
    end
  endtask

  task automatic test_dual_bubble();
    int cnt0;
    cnt0 = int'(bubble_cnt);
    rand_id();
    ctl(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    total++;
    if (dut_ex !== nop_ex() || int'(bubble_cnt) !== cnt0 + 1) begin
      bad++;
      $display("FAIL dual_bubble got ex=%h cnt=%0d exp cnt=%0d", dut_ex, bubble_cnt, cnt0 + 1);
    end
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_hold();
    int cnt0;
    rand_id();
    id_valid = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    cnt0 = int'(bubble_cnt);
    rand_id();
    id_valid = 1'b1; id_pc = 32'h500;
    ctl(1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    total++;
    if (pc_stall !== 1'b0 || ifid_stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got %b/%b exp 0/0", pc_stall, ifid_stall);
    end
    step();
    total++;
    if (ex_valid !== 1'b0 || ex_Rw !== 5'd0 || int'(bubble_cnt) !== cnt0 || dut_ex !== m_ex) begin
      bad++;
      $display("FAIL flush_ex got v=%b rw=%0d cnt=%0d exp 0/0/%0d", ex_valid, ex_Rw, bubble_cnt, cnt0);
    end
  endtask

  task automatic test_hold_bubble();
    ex_t frozen;
    int cnt0;
    rand_id();
    id_valid = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    frozen = id_ex();
    cnt0 = int'(bubble_cnt);
    rand_id();
    ctl(1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    total++;
    if (pc_stall !== 1'b1 || ifid_stall !== 1'b1) begin
      bad++;
      $display("FAIL hold_stall got %b/%b exp 1/1", pc_stall, ifid_stall);
    end
    step();
    total++;
    if (dut_ex !== frozen || int'(bubble_cnt) !== cnt0) begin
      bad++;
      $display("FAIL hold_freeze got %h cnt=%0d exp %h cnt=%0d", dut_ex, bubble_cnt, frozen, cnt0);
    end
    hold = 1'b0;
    step();
    total++;
    if (dut_ex !== nop_ex() || int'(bubble_cnt) !== cnt0 + 1) begin
      bad++;
      $display("FAIL hold_release got %h cnt=%0d exp cnt=%0d", dut_ex, bubble_cnt, cnt0 + 1);
    end
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_id();
      rst_n = ($urandom_range(0, 40) != 0);
      ctl(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      #1;
      total++;
      if (pc_stall !== exp_stall() || ifid_stall !== exp_stall()) begin
        bad++;
        $display("FAIL rand_stall cyc %0d got %b/%b exp %b", i, pc_stall, ifid_stall, exp_stall());
      end
      step();
      total++;
      if (dut_ex !== m_ex || int'(bubble_cnt) !== m_cnt) begin
        bad++;
        $display("FAIL rand_ex cyc %0d got %h cnt=%0d exp %h cnt=%0d", i, dut_ex, bubble_cnt, m_ex, m_cnt);
      end
    end
    rst_n = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX - 1; i++) step();
    total++;
    if (int'(bubble_cnt) !== CNT_MAX - 1) begin
      bad++;
      $display("FAIL sat_preload got %h exp %h", bubble_cnt, CNT_MAX - 1);
    end
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      total++;
      if (int'(bubble_cnt) !== CNT_MAX || int'(bubble_cnt) !== m_cnt) begin
        bad++;
        $display("FAIL sat_hold cyc %0d got %h exp %h", i, bubble_cnt, CNT_MAX);
      end
    end
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_ex = nop_ex();
    m_cnt = 0;
    rst_n = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    rand_id();
    @(posedge clk);
    #1;
    test_reset();
    test_plain_flow();
    test_mfc0();
    test_dual_bubble();
    test_flush_hold();
    test_hold_bubble();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
